// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack-machine datapath: fetch/decode,
// datapath enables and selects, run/halt control and a retired-instruction counter.
module stack_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [2:0]       opcode,
  input  logic [7:0]       tos,
  output logic             addrSrc,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mdr_en,
  output logic             pc_write,
  output logic             jump,
  output logic             load_a,
  output logic             load_b,
  output logic [1:0]       alu_control,
  output logic             push,
  output logic             pop,
  output logic             stack_src,
  output logic             busy,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_POPA,
    S_POPB,
    S_EXEC,
    S_MEMRD,
    S_PUSHM,
    S_POPW,
    S_JUMP
  } state_t;

  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addrSrc     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mdr_en      = 1'b0;
    pc_write    = 1'b0;
    jump        = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    alu_control = 2'b00;
    push        = 1'b0;
    pop         = 1'b0;
    stack_src   = 1'b0;
    retire      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_PUSH: state_d = S_MEMRD;
          OP_POP:  state_d = S_POPW;
          OP_JMP:  state_d = S_JUMP;
          OP_JZ: begin
            // Untaken JZ finishes here, so it retires in DECODE.
            if (tos == 8'h00) state_d = S_JUMP;
            else              retire  = 1'b1;
          end
          default: state_d = S_POPA;
        endcase
      end
      S_POPA: begin
        load_a  = 1'b1;
        pop     = 1'b1;
        state_d = (opcode == OP_NOT) ? S_EXEC : S_POPB;
      end
      S_POPB: begin
        load_b  = 1'b1;
        pop     = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_control = opcode[1:0];
        push        = 1'b1;
        retire      = 1'b1;
      end
      S_MEMRD: begin
        addrSrc  = 1'b1;
        mem_read = 1'b1;
        mdr_en   = 1'b1;
        state_d  = S_PUSHM;
      end
      S_PUSHM: begin
        stack_src = 1'b1;
        push      = 1'b1;
        retire    = 1'b1;
      end
      S_POPW: begin
        addrSrc   = 1'b1;
        mem_write = 1'b1;
        pop       = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        jump     = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      state_d = halt_req ? S_IDLE : S_FETCH;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_stack_controller.sv
// Directed and randomized checks of stack_controller against a per-instruction
// cycle table derived from the opcode map, with CNT_W=4 to exercise wrap.
module tb_stack_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, halt_req;
  logic [2:0]    opcode;
  logic [7:0]    tos;
  logic          addrSrc, mem_read, mem_write, ir_write, mdr_en, pc_write, jump;
  logic          load_a, load_b, push, pop, stack_src, busy, retire;
  logic [1:0]    alu_control;
  logic [CW-1:0] retired_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cnt_m    = 0;

  stack_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .opcode(opcode), .tos(tos),
    .addrSrc(addrSrc), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_en(mdr_en), .pc_write(pc_write), .jump(jump),
    .load_a(load_a), .load_b(load_b), .alu_control(alu_control),
    .push(push), .pop(pop), .stack_src(stack_src),
    .busy(busy), .retire(retire), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {addrSrc, mem_read, mem_write, ir_write, mdr_en, pc_write, jump,
                load_a, load_b, alu_control, push, pop, stack_src, busy, retire};

  function automatic logic [15:0] v(input bit as_, mr, mw, irw, mdr, pcw, jmp,
                                    la, lb, input logic [1:0] alu,
                                    input bit ps, pp, ss, bsy, ret);
    return {as_, mr, mw, irw, mdr, pcw, jmp, la, lb, alu, ps, pp, ss, bsy, ret};
  endfunction

  localparam logic [15:0] ZERO = 16'h0000;

  task automatic chk_vec(input string tag, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [CW-1:0] e;
    e = CW'(cnt_m);
    checks++;
    assert (retired_cnt === e) else begin
      failures++;
      $error("FAIL %s retired_cnt observed=%h expected=%h", tag, retired_cnt, e);
    end
  endtask

  // Idle cycle with start high; Moore outputs stay zero, FETCH follows.
  task automatic start_run(input bit h);
    start = 1'b1; halt_req = h; opcode = 3'($urandom); tos = 8'($urandom);
    #1;
    chk_vec("idle_start", ZERO);
    chk_cnt("idle_cnt");
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Entered one tick after the FETCH edge; runs one whole instruction.
  task automatic do_instr(input logic [2:0] op, input logic [7:0] t, input bit halt);
    logic [15:0] seq[6];
    int n;
    bit  jzt, jznt;
    jzt  = (op == 3'b111) && (t == 8'h00);
    jznt = (op == 3'b111) && (t != 8'h00);
    n = 0;
    seq[n++] = v(0,1,0,1,0,1,0,0,0,2'b00,0,0,0,1,0);
    seq[n++] = v(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,1,jznt);
    if (op[2] == 1'b0) begin
      seq[n++] = v(0,0,0,0,0,0,0,1,0,2'b00,0,1,0,1,0);
      if (op != 3'b011) seq[n++] = v(0,0,0,0,0,0,0,0,1,2'b00,0,1,0,1,0);
      seq[n++] = v(0,0,0,0,0,0,0,0,0,op[1:0],1,0,0,1,1);
    end else if (op == 3'b100) begin
      seq[n++] = v(1,1,0,0,1,0,0,0,0,2'b00,0,0,0,1,0);
      seq[n++] = v(0,0,0,0,0,0,0,0,0,2'b00,1,0,1,1,1);
    end else if (op == 3'b101) begin
      seq[n++] = v(1,0,1,0,0,0,0,0,0,2'b00,0,1,0,1,1);
    end else if (op == 3'b110 || jzt) begin
      seq[n++] = v(0,0,0,0,0,1,1,0,0,2'b00,0,0,0,1,1);
    end
    for (int i = 0; i < n; i++) begin
      opcode   = (i == 0) ? 3'($urandom) : op;
      tos      = (i == 1) ? t : 8'($urandom);
      halt_req = (i == n - 1) ? halt : (halt | 1'($urandom));
      start    = 1'($urandom);
      #1;
      chk_vec($sformatf("op%0d_tos%0h_cyc%0d", op, t, i), seq[i]);
      chk_cnt($sformatf("op%0d_cnt_cyc%0d", op, i));
      @(posedge clk); #1;
    end
    cnt_m = (cnt_m + 1) % (1 << CW);
    if (halt) begin
      start = 1'b0; halt_req = 1'b0;
      #1;
      chk_vec("halted_idle", ZERO);
      chk_cnt("halted_cnt");
    end
  endtask

  initial begin
    logic [2:0] rop;
    logic [7:0] rt;
    bit         rh;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; opcode = '0; tos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_vec("reset_outputs", ZERO);
    chk_cnt("reset_cnt");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_vec("idle_no_start", ZERO);

    start_run(1'b0);
    do_instr(3'b001, 8'h33, 1'b0);  // SUB
    do_instr(3'b011, 8'h00, 1'b0);  // NOT
    do_instr(3'b000, 8'h12, 1'b0);  // ADD
    do_instr(3'b100, 8'h00, 1'b0);  // PUSH
    do_instr(3'b101, 8'h7f, 1'b0);  // POP
    do_instr(3'b111, 8'h00, 1'b0);  // JZ taken
    do_instr(3'b111, 8'h05, 1'b0);  // JZ not taken
    do_instr(3'b110, 8'h00, 1'b0);  // JMP
    do_instr(3'b010, 8'hff, 1'b1);  // AND with halt
    start_run(1'b1);                // start beats halt_req
    do_instr(3'b000, 8'h01, 1'b1);  // ADD halted

    for (int k = 0; k < 60; k++) begin
      if (!busy) start_run(1'($urandom));
      rop = 3'($urandom);
      rt  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      rh  = ($urandom_range(0, 7) == 0);
      do_instr(rop, rt, rh);
    end

    // Reset while in MEMRD abandons the PUSH.
    if (!busy) start_run(1'b0);
    opcode = 3'b100; halt_req = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_vec("memrd_before_rst", v(1,1,0,0,1,0,0,0,0,2'b00,0,0,0,1,0));
    rst = 1'b1;
    @(posedge clk); #1;
    cnt_m = 0;
    chk_vec("rst_mid_memrd", ZERO);
    chk_cnt("rst_mid_cnt");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_vec("post_rst_idle", ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
